// File: rtl/sprite_dma_arbiter.sv
// sprite_dma_arbiter: shares the system bus between the CPU and an OAM sprite-DMA engine
// Ports:
//   i_clk, i_reset_n                  clock, asynchronous active-low reset
//   i_cpu_rw/address/data             CPU bus request (rw 1=read 0=write)
//   o_cpu_rdy                         1 = CPU may advance, 0 = CPU stalled
//   o_rw, o_address, o_data, i_data   bus to the memory/PPU decode
//   o_dma_active                      1 while the DMA engine owns the bus
module sprite_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] DMA_DEST_ADDR = 16'h2004,
  parameter int          TRANSFER_LEN  = 256
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  output logic        o_cpu_rdy,
  output logic        o_rw,
  output logic [15:0] o_address,
  output logic [7:0]  o_data,
  input  logic [7:0]  i_data,
  output logic        o_dma_active
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  localparam logic [7:0] LAST_IDX = 8'(TRANSFER_LEN - 1);
  state_t     state;
  logic [7:0] r_page, r_idx, r_byte;
  logic       r_odd;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      r_page <= '0;
      r_idx  <= '0;
      r_byte <= '0;
      r_odd  <= 1'b0;
    end else begin
      r_odd <= ~r_odd;
      case (state)
        IDLE:
          if (!i_cpu_rw && i_cpu_address == DMA_REG_ADDR) begin
            r_page <= i_cpu_data;
            r_idx  <= '0;
            state  <= HALT;
          end
        // an odd HALT lets the first READ land on an even cycle without ALIGN
        HALT:  state <= r_odd ? READ : ALIGN;
        ALIGN: state <= READ;
        READ: begin
          r_byte <= i_data;
          state  <= WRITE;
        end
        WRITE:
          if (r_idx == LAST_IDX) begin
            r_idx <= '0;
            state <= IDLE;
          end else begin
            r_idx <= r_idx + 8'd1;
            state <= READ;
          end
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    o_cpu_rdy    = state == IDLE;
    o_dma_active = !o_cpu_rdy;
    o_rw         = o_cpu_rdy ? i_cpu_rw : state != WRITE;
    o_address    = state == READ  ? {r_page, r_idx} :
                   state == WRITE ? DMA_DEST_ADDR : i_cpu_address;
    o_data       = o_cpu_rdy ? i_cpu_data : state == WRITE ? r_byte : 8'h00;
  end
endmodule

// File: tb/tb_sprite_dma_arbiter.sv
// tb_sprite_dma_arbiter: random CPU traffic and DMA triggers checked against a schedule model
module tb_sprite_dma_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [15:0] cpu_addr = 16'h8000;
  logic [7:0]  cpu_data = 8'h00;
  logic        cpu_rdy, bus_rw, dma_active;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;
  logic [7:0]  mem [0:65535];
  int          checks = 0, passes = 0, stall_cnt = 0;
  logic [7:0]  wr_q [$];
  logic [15:0] rd_q [$];
  bit          m_busy, m_align, m_odd;
  int          m_k;
  logic [7:0]  m_page;

  always #5 clk = ~clk;
  assign bus_rdata = mem[bus_addr];

  sprite_dma_arbiter dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cpu_rw(cpu_rw), .i_cpu_address(cpu_addr),
    .i_cpu_data(cpu_data), .o_cpu_rdy(cpu_rdy), .o_rw(bus_rw), .o_address(bus_addr),
    .o_data(bus_wdata), .i_data(bus_rdata), .o_dma_active(dma_active)
  );

  // Model: a DMA is a stall window of 1 + align + 512 cycles, indexed by m_k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_odd  <= 1'b0;
      m_k    <= 0;
    end else begin
      m_odd <= ~m_odd;
      if (!m_busy) begin
        if (!cpu_rw && cpu_addr == 16'h4014) begin
          m_busy  <= 1'b1;
          m_k     <= 0;
          m_page  <= cpu_data;
          m_align <= m_odd;
        end
      end else begin
        if (m_k == 512 + int'(m_align)) m_busy <= 1'b0;
        m_k <= m_k + 1;
      end
    end
  end

  initial forever begin
    int j;
    logic e_rw;
    logic [15:0] e_a;
    logic [7:0] e_d;
    @(negedge clk);
    e_rw = cpu_rw; e_a = cpu_addr; e_d = cpu_data;
    if (m_busy) begin
      j = m_k - 1 - int'(m_align);
      if (j < 0) begin e_rw = 1'b1; e_a = cpu_addr; e_d = 8'h00; end
      else if (j % 2 == 0) begin e_rw = 1'b1; e_a = {m_page, 8'(j / 2)}; e_d = 8'h00; end
      else begin e_rw = 1'b0; e_a = 16'h2004; e_d = mem[{m_page, 8'(j / 2)}]; end
    end
    checks++;
    if ({cpu_rdy, dma_active, bus_rw, bus_addr, bus_wdata} === {!m_busy, m_busy, e_rw, e_a, e_d})
      passes++;
    else
      $display("FAIL bus t=%0t got rdy=%b act=%b rw=%b a=%h d=%h want rdy=%b act=%b rw=%b a=%h d=%h",
               $time, cpu_rdy, dma_active, bus_rw, bus_addr, bus_wdata, !m_busy, m_busy, e_rw, e_a, e_d);
    if (!cpu_rdy) begin
      stall_cnt++;
      if (!bus_rw && bus_addr == 16'h2004) wr_q.push_back(bus_wdata);
      else if (bus_addr != cpu_addr) rd_q.push_back(bus_addr);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h want=%0h", name, got, exp);
  endtask

  task automatic drive(input logic rw, input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    cpu_rw = rw; cpu_addr = a; cpu_data = d;
  endtask

  task automatic idle_rand(input int n);
    logic [15:0] a;
    logic rw;
    repeat (n) begin
      a = 16'($urandom);
      rw = 1'($urandom);
      if (!rw && a == 16'h4014) a = 16'h4015;
      drive(rw, a, 8'($urandom));
    end
  endtask

  task automatic trigger(input logic [7:0] p, input bit want_odd);
    stall_cnt = 0;
    wr_q.delete();
    rd_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (m_odd == want_odd) begin
        cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_data = p;
        break;
      end
      cpu_rw = 1'b1; cpu_addr = 16'h8000; cpu_data = 8'h00;
    end
    drive(1'b1, 16'hC000, 8'h00);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      #2;
      if (stall_cnt > 0 && cpu_rdy) return;
    end
    chk("dma_done_timeout", 0, 1);
  endtask

  initial begin
    bit w;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #2;
    chk("reset_rdy", 32'(cpu_rdy), 1);
    chk("reset_act", 32'(dma_active), 0);
    chk("pass_addr", 32'(bus_addr), 32'h8000);
    chk("pass_rw_rd", 32'(bus_rw), 1);
    drive(1'b0, 16'h0300, 8'h5A);
    @(negedge clk); #2;
    chk("pass_rw_wr", 32'(bus_rw), 0);
    chk("pass_data", 32'(bus_wdata), 32'h5A);
    idle_rand(20);
    trigger(8'h02, 1'b1);
    wait_done();
    chk("stall_align", stall_cnt, 514);
    chk("wr_count", wr_q.size(), 256);
    chk("rd_count", rd_q.size(), 256);
    if (wr_q.size() == 256) begin
      chk("wr_first", 32'(wr_q[0]), 32'hA5);
      chk("wr_1", 32'(wr_q[1]), 32'hA4);
      chk("wr_last", 32'(wr_q[255]), 32'h5A);
    end
    if (rd_q.size() == 256) begin
      chk("rd_first", 32'(rd_q[0]), 32'h0200);
      chk("rd_last", 32'(rd_q[255]), 32'h02FF);
    end
    idle_rand(10);
    trigger(8'h02, 1'b0);
    wait_done();
    chk("stall_noalign", stall_cnt, 513);
    chk("wr_count2", wr_q.size(), 256);
    if (wr_q.size() == 256) chk("wr_mid", 32'(wr_q[128]), 32'h25);
    idle_rand(7);
    w = 1'($urandom);
    trigger(8'hFF, w);
    wait_done();
    chk("stall_ff", stall_cnt, w ? 514 : 513);
    chk("pass_restored", 32'(bus_addr), 32'hC000);
    if (rd_q.size() != 0) chk("rd_ffff", 32'(rd_q[$]), 32'hFFFF);
    if (wr_q.size() != 0) chk("wr_ffff", 32'(wr_q[$]), 32'(mem[16'hFFFF]));
    idle_rand(5);
    trigger(8'h02, 1'($urandom));
    for (int i = 0; i < 200 && wr_q.size() < 40; i++) begin
      @(negedge clk);
      #2;
    end
    chk("abort_at_40", wr_q.size(), 40);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_rdy", 32'(cpu_rdy), 1);
    chk("abort_act", 32'(dma_active), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_rand(600);
    chk("no_writes_after_abort", wr_q.size(), 40);
    stall_cnt = 0;
    drive(1'b1, 16'h4014, 8'h07);
    drive(1'b0, 16'h4015, 8'h33);
    idle_rand(5);
    @(negedge clk); #2;
    chk("no_trigger_stall", stall_cnt, 0);
    chk("no_trigger_rdy", 32'(cpu_rdy), 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sprite_dma_arbiter.md
Name: sprite_dma_arbiter

Overview:
Owns the system address/data bus between the Cpu6502 core and an OAM sprite-DMA engine.
- When idle, it passes the CPU's bus straight through.
- A CPU write to DMA_REG_ADDR latches a source page, deasserts o_cpu_rdy to stall the core, and copies TRANSFER_LEN bytes from {page,00}.. to DMA_DEST_ADDR as read/write pairs.
- It then hands the bus back to the CPU.
- It sits between the CPU top level and the memory/PPU decode.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU write address that triggers a DMA; written data is the source page.
DMA_DEST_ADDR, 16'h2004, fixed destination address for every DMA write.
TRANSFER_LEN, 256, bytes per DMA; range 1..256; 8-bit index.

Ports:
i_clk  input  1  system clock, all state on rising edge
i_reset_n  input  1  asynchronous active-low reset
i_cpu_rw  input  1  CPU read/write, 1=READ 0=WRITE
i_cpu_address  input  16  CPU address
i_cpu_data  input  8  CPU write data
o_cpu_rdy  output  1  1=CPU may advance, 0=CPU must hold its current cycle
o_rw  output  1  bus read/write to memory system
o_address  output  16  bus address to memory system
o_data  output  8  bus write data
i_data  input  8  bus read data from memory system
o_dma_active  output  1  1 while arbiter owns the bus (any non-IDLE state)

Behaviour:
- Reset (async, i_reset_n=0):
  - state=IDLE, r_page=0, r_idx=0, r_byte=0, r_odd=0.
  - Outputs: o_cpu_rdy=1, o_dma_active=0, bus in passthrough.
  - Reset mid-DMA aborts immediately; no further DMA writes.
- r_odd toggles on every clock edge after reset release. The first cycle after release has r_odd=0 (even).
- States: IDLE, HALT, ALIGN, READ, WRITE. Outputs decode combinationally from registered state.
  - o_cpu_rdy = (state==IDLE).
  - o_dma_active = !o_cpu_rdy.
- IDLE:
  - Passthrough: o_rw=i_cpu_rw, o_address=i_cpu_address, o_data=i_cpu_data.
  - The CPU's write to DMA_REG_ADDR completes on the bus normally.
  - If i_cpu_rw=0 and i_cpu_address==DMA_REG_ADDR: r_page<=i_cpu_data, r_idx<=0, state<=HALT.
- HALT: one dummy cycle.
  - Bus: o_rw=1, o_address=i_cpu_address, o_data=0.
  - Next state: if r_odd==0 then ALIGN, else READ. Guarantees every READ falls on r_odd==0.
- ALIGN: one extra dummy cycle; bus as HALT; next state READ.
- READ:
  - Bus: o_rw=1, o_address={r_page,r_idx}, o_data=0.
  - r_byte<=i_data at the end of the cycle; state<=WRITE.
- WRITE:
  - Bus: o_rw=0, o_address=DMA_DEST_ADDR, o_data=r_byte.
  - If r_idx==TRANSFER_LEN-1: state<=IDLE, r_idx<=0.
  - Else: r_idx<=r_idx+1 (8-bit), state<=READ.
- Cycle counts:
  - Trigger write in cycle N; o_cpu_rdy=0 from cycle N+1.
  - Stall length: 1 + align(0/1) + 2*TRANSFER_LEN cycles, i.e. 513 or 514 for 256.
  - o_cpu_rdy=1 in the cycle after the final WRITE.
- Writes to DMA_REG_ADDR while not IDLE are ignored. The CPU is stalled, so none are expected.
- Source address never crosses the page: r_idx 0..255 with page fixed.
- A CPU read of DMA_REG_ADDR does not trigger a DMA.
- TRANSFER_LEN=256 compares r_idx to 8'hFF.

Test Plan:
- Reset held, then released; CPU issues read 0x8000 -> o_cpu_rdy=1, o_address=0x8000, o_rw=1, o_dma_active=0; CPU write 0x0300 data 0x5A -> o_rw=0, o_data=0x5A.
- Preload RAM 0x0200+i = i^0xA5; CPU writes 0x02 to 0x4014 when trigger cycle has r_odd=1 (HALT lands even) -> exactly 514 cycles of o_cpu_rdy=0. The 256 writes to 0x2004 carry data 0xA5,0xA4,...,0x5A in order; reads hit 0x0200..0x02FF ascending.
- Same trigger shifted by one cycle -> 513 stall cycles. Every READ cycle has r_odd==0, no ALIGN cycle.
- Trigger with page 0xFF -> last read address 0xFFFF, no carry into the next page; final write data matches RAM[0xFFFF]; o_cpu_rdy returns 1 the next cycle with passthrough restored.
- Assert i_reset_n=0 asynchronously after 40 DMA writes -> o_cpu_rdy=1 and o_dma_active=0 immediately (same cycle). After release, no writes to 0x2004 occur without a new trigger.
- CPU read of 0x4014, and a write to 0x4015 -> no DMA started, o_cpu_rdy stays 1.
